// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the EX stage of the MIPS core.
//   MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
//   Both retire one bit per cycle. An operation occupies the unit for
//   DATA_W + 2 cycles: one cycle in PREP, DATA_W cycles in RUN, and one cycle
//   in FIN. The architectural HI/LO registers live here. MTHI/MTLO write them
//   while the unit is idle.
//
//   Optional build macro:
//     MDU_DIV0_FLAG_EN - adds the div_zero output. It is set when a divide
//                        retires with a zero divisor and is cleared when the
//                        next operation is accepted.
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              mthi_en,
   input  logic              mtlo_en,
   output logic              busy,
   output logic              done,
`ifdef MDU_DIV0_FLAG_EN
   output logic              div_zero,
`endif
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_RUN  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   // Architectural state and latched request
   state_t              state;
   logic [1:0]          op_r;      // op[0]=1 -> unsigned, op[1]=1 -> divide
   logic [DATA_W-1:0]   a_r;       // original rs, also HI on divide-by-zero
   logic [DATA_W-1:0]   b_r;       // original rt

   // Iteration datapath
   logic [DATA_W-1:0]   m_r;       // multiplicand (mult) or divisor (div) magnitude
   logic [DATA_W-1:0]   q_r;       // multiplier -> product low / dividend -> quotient
   logic [DATA_W-1:0]   acc_r;     // product high half / partial remainder
   logic [CNT_W-1:0]    cnt;
   logic                neg_q;     // negate product or quotient at FIN
   logic                neg_r;     // negate remainder at FIN
   logic                div0_r;    // divisor was zero

   // Operand decode
   logic                is_signed;
   logic                is_div;
   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;

   // One iteration step of each algorithm
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W-1:0]   mul_acc_nxt;
   logic [DATA_W-1:0]   mul_q_nxt;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic [DATA_W-1:0]   div_acc_nxt;
   logic [DATA_W-1:0]   div_q_nxt;

   // Final HI/LO values
   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   fin_hi;
   logic [DATA_W-1:0]   fin_lo;

   // Decode the latched request into sign flags and operand magnitudes
   always_comb begin
      is_signed = ~op_r[0];
      is_div    = op_r[1];
      a_neg     = is_signed & a_r[DATA_W-1];
      b_neg     = is_signed & b_r[DATA_W-1];
      // The most negative value maps onto itself, which is the correct unsigned magnitude
      a_mag     = a_neg ? (~a_r + 1'b1) : a_r;
      b_mag     = b_neg ? (~b_r + 1'b1) : b_r;
   end

   // Compute one shift-add and one restoring-divide step from the current state
   always_comb begin
      // NOTE: every signal assigned here gets a value on every path; otherwise a latch is inferred
      mul_sum     = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : '0);
      mul_acc_nxt = mul_sum[DATA_W:1];
      mul_q_nxt   = {mul_sum[0], q_r[DATA_W-1:1]};

      div_shift   = {acc_r, q_r[DATA_W-1]};
      div_diff    = div_shift - {1'b0, m_r};
      // A set top bit is a borrow, so the divisor did not fit and the remainder is restored
      if (div_diff[DATA_W]) begin
         div_acc_nxt = div_shift[DATA_W-1:0];
         div_q_nxt   = {q_r[DATA_W-2:0], 1'b0};
      end else begin
         div_acc_nxt = div_diff[DATA_W-1:0];
         div_q_nxt   = {q_r[DATA_W-2:0], 1'b1};
      end
   end

   // Apply the sign fix-up and select the HI/LO values written at FIN
   always_comb begin
      prod     = {acc_r, q_r};
      prod_fix = neg_q ? (~prod + 1'b1) : prod;
      quo_fix  = neg_q ? (~q_r + 1'b1) : q_r;
      rem_fix  = neg_r ? (~acc_r + 1'b1) : acc_r;
      if (!is_div) begin
         fin_hi = prod_fix[2*DATA_W-1:DATA_W];
         fin_lo = prod_fix[DATA_W-1:0];
      end else if (div0_r) begin
         fin_hi = a_r;
         fin_lo = '1;
      end else begin
         fin_hi = rem_fix;
         fin_lo = quo_fix;
      end
   end

   // Control FSM, iteration datapath and HI/LO registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         m_r      <= '0;
         q_r      <= '0;
         acc_r    <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div0_r   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
         div_zero <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // A move-to-HI/LO has priority over a start in the same cycle
               if (mthi_en || mtlo_en) begin
                  if (mthi_en) hi <= src_a;
                  if (mtlo_en) lo <= src_a;
               end else if (start) begin
                  op_r     <= op;
                  a_r      <= src_a;
                  b_r      <= src_b;
                  busy     <= 1'b1;
                  state    <= S_PREP;
`ifdef MDU_DIV0_FLAG_EN
                  div_zero <= 1'b0;
`endif
               end
            end

            S_PREP: begin
               // Multiply iterates over the multiplier bits; divide shifts the dividend in
               m_r    <= is_div ? b_mag : a_mag;
               q_r    <= is_div ? a_mag : b_mag;
               acc_r  <= '0;
               cnt    <= '0;
               neg_q  <= a_neg ^ b_neg;
               neg_r  <= a_neg;
               div0_r <= (b_r == '0);
               state  <= S_RUN;
            end

            S_RUN: begin
               if (is_div) begin
                  acc_r <= div_acc_nxt;
                  q_r   <= div_q_nxt;
               end else begin
                  acc_r <= mul_acc_nxt;
                  q_r   <= mul_q_nxt;
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST_CNT) state <= S_FIN;
            end

            S_FIN: begin
               hi       <= fin_hi;
               lo       <= fin_lo;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
`ifdef MDU_DIV0_FLAG_EN
               div_zero <= is_div & div0_r;
`endif
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
